// File: rtl/softusb_rxfilter.sv
// rtl/softusb_rxfilter.sv - receive-line conditioner: synchroniser, glitch filter, line state
//
// Purpose: brings the asynchronous transceiver outputs (rcv, vp, vm) into the
// usb_clk domain, rejects short pulses with a persistence filter and derives
// the bus line state with a qualified SE0 detector and an SE1 error flag.
//
// Ports:
//   usb_clk      - sole clock
//   usb_rst      - synchronous, active-high reset
//   rcv, vp, vm  - asynchronous receiver outputs
//   rcv_s, vp_s, vm_s - synchronised, filtered channels
//   linestate    - {vp_s, vm_s}: 00 SE0, 10 D+ high, 01 D- high, 11 SE1
//   se0_valid    - filtered SE0 held for at least SE0_MIN cycles (registered)
//   se1_err      - filtered line was SE1 on the previous edge (registered)
//   glitch_count - saturating count of edges with at least one rejected glitch
//
// Optional feature: define SOFTUSB_RXFILTER_GLITCHCNT_EN to build the glitch
// counter; otherwise glitch_count is tied to zero.

module softusb_rxfilter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int SE0_MIN     = 3
) (
  input  logic        usb_clk,
  input  logic        usb_rst,
  input  logic        rcv,
  input  logic        vp,
  input  logic        vm,
  output logic        rcv_s,
  output logic        vp_s,
  output logic        vm_s,
  output logic [1:0]  linestate,
  output logic        se0_valid,
  output logic        se1_err,
  output logic [15:0] glitch_count
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(SE0_MIN + 1);

  // Channel index: 0 = rcv, 1 = vp, 2 = vm.
  logic [2:0]             pad;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             s;
  logic [2:0]             o_q;
  logic [CW-1:0]          run_q  [3];
  logic [SW-1:0]          se0_cnt_q;
  logic                   se0_now;

  assign pad = {vm, vp, rcv};

  always_comb begin
    s = '0;
    for (int i = 0; i < 3; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Synchroniser chains and persistence filters.
  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= '0;
        run_q[i]  <= '0;
      end
      o_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad[i]};
        if (s[i] == o_q[i]) begin
          run_q[i] <= '0;
        end else if (run_q[i] == CW'(FILTER_LEN - 1)) begin
          // The new level has persisted long enough: accept it.
          o_q[i]   <= s[i];
          run_q[i] <= '0;
        end else begin
          run_q[i] <= run_q[i] + CW'(1);
        end
      end
    end
  end

  assign rcv_s     = o_q[0];
  assign vp_s      = o_q[1];
  assign vm_s      = o_q[2];
  assign linestate = {vp_s, vm_s};
  assign se0_now   = (linestate == 2'b00);

  // SE0 qualifier: se0_valid rises on the edge that sees the SE0_MIN-th
  // consecutive SE0 sample, so the check uses the pre-increment count.
  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      se0_cnt_q <= '0;
      se0_valid <= 1'b0;
      se1_err   <= 1'b0;
    end else begin
      if (se0_now) begin
        if (se0_cnt_q != SW'(SE0_MIN)) begin
          se0_cnt_q <= se0_cnt_q + SW'(1);
        end
      end else begin
        se0_cnt_q <= '0;
      end
      se0_valid <= se0_now && (se0_cnt_q >= SW'(SE0_MIN - 1));
      se1_err   <= (linestate == 2'b11);
    end
  end

`ifdef SOFTUSB_RXFILTER_GLITCHCNT_EN
  logic [2:0]  reject;
  logic [15:0] glitch_cnt_q;

  // A run that ends without being accepted leaves a nonzero run counter
  // behind on the edge where the input has returned to the output level.
  always_comb begin
    reject = '0;
    for (int i = 0; i < 3; i++) begin
      reject[i] = (s[i] == o_q[i]) && (run_q[i] != '0);
    end
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      glitch_cnt_q <= '0;
    end else if ((|reject) && (glitch_cnt_q != 16'hFFFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 16'd1;
    end
  end

  assign glitch_count = glitch_cnt_q;
`else
  assign glitch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_softusb_rxfilter.sv
// tb/tb_softusb_rxfilter.sv - self-checking bench for softusb_rxfilter

module tb_softusb_rxfilter;

  localparam int SS = 2;
  localparam int FL = 2;
  localparam int SM = 3;
`ifdef SOFTUSB_RXFILTER_GLITCHCNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic        usb_clk;
  logic        usb_rst;
  logic        rcv, vp, vm;
  logic        rcv_s, vp_s, vm_s;
  logic [1:0]  linestate;
  logic        se0_valid, se1_err;
  logic [15:0] glitch_count;

  logic        d2_rcv_s, d2_vp_s, d2_vm_s;
  logic [1:0]  d2_linestate;
  logic        d2_se0_valid, d2_se1_err;
  logic [15:0] d2_glitch_count;

  softusb_rxfilter #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .SE0_MIN(SM)) u_dut (
    .usb_clk(usb_clk), .usb_rst(usb_rst), .rcv(rcv), .vp(vp), .vm(vm),
    .rcv_s(rcv_s), .vp_s(vp_s), .vm_s(vm_s), .linestate(linestate),
    .se0_valid(se0_valid), .se1_err(se1_err), .glitch_count(glitch_count)
  );

  softusb_rxfilter #(.SYNC_STAGES(3), .FILTER_LEN(1), .SE0_MIN(SM)) u_dut2 (
    .usb_clk(usb_clk), .usb_rst(usb_rst), .rcv(rcv), .vp(vp), .vm(vm),
    .rcv_s(d2_rcv_s), .vp_s(d2_vp_s), .vm_s(d2_vm_s), .linestate(d2_linestate),
    .se0_valid(d2_se0_valid), .se1_err(d2_se1_err), .glitch_count(d2_glitch_count)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge usb_clk);
    #1;
  endtask

  // Behavioural model: the filter input is the pad value sampled SS edges
  // earlier; a channel output takes a new level once the last FL samples all
  // differ from it; a glitch is a differing sample followed by a return.
  bit [2:0] padq [$];
  bit [2:0] sq   [$];
  bit [2:0] s_prev;
  bit [2:0] m_o;
  int       m_run;
  bit       m_se0v, m_se1;
  int       m_gc;

  always @(posedge usb_clk) begin
    if (usb_rst) begin
      padq = {};
      sq   = {};
      for (int k = 0; k < SS; k++) padq.push_back(3'b000);
      for (int k = 0; k < FL; k++) sq.push_back(3'b000);
      s_prev = '0; m_o = '0; m_run = 0; m_se0v = 0; m_se1 = 0; m_gc = 0;
    end else if (padq.size() == SS) begin
      bit [1:0] ls_pre;
      bit [2:0] s, o_new;
      bit       rej, acc;
      ls_pre = {m_o[1], m_o[2]};
      s = padq.pop_front();
      padq.push_back({vm, vp, rcv});
      void'(sq.pop_front());
      sq.push_back(s);
      rej = 0;
      o_new = m_o;
      for (int i = 0; i < 3; i++) begin
        if (s[i] == m_o[i] && s_prev[i] != m_o[i]) rej = 1;
        acc = 1;
        foreach (sq[k]) if (sq[k][i] == m_o[i]) acc = 0;
        if (acc) o_new[i] = s[i];
      end
      if (ls_pre == 2'b00) m_run++; else m_run = 0;
      m_se0v = (m_run >= SM);
      m_se1  = (ls_pre == 2'b11);
      if (GC_EN && rej && m_gc < 65535) m_gc++;
      s_prev = s;
      m_o = o_new;
    end
  end

  always @(negedge usb_clk) begin
    if (chk_en) begin
      check("rcv_s", 32'(rcv_s), 32'(m_o[0]));
      check("vp_s", 32'(vp_s), 32'(m_o[1]));
      check("vm_s", 32'(vm_s), 32'(m_o[2]));
      check("linestate", 32'(linestate), 32'({m_o[1], m_o[2]}));
      check("se0_valid", 32'(se0_valid), 32'(m_se0v));
      check("se1_err", 32'(se1_err), 32'(m_se1));
      check("glitch_count", 32'(glitch_count), 32'(m_gc));
    end
  end

  initial begin
    int n, lat1, lat2, cnt, cnt2;
    int i_ls, i_v, i_e, i_f;
    bit hit1, hit2;

    usb_rst = 1'b1; rcv = 0; vp = 1; vm = 0;

    // Reset with vp high: everything reads zero during and just after.
    step(1);
    check("rst_vp_s", 32'(vp_s), 32'd0);
    check("rst_linestate", 32'(linestate), 32'd0);
    check("rst_se0_valid", 32'(se0_valid), 32'd0);
    check("rst_glitch", 32'(glitch_count), 32'd0);
    step(1);
    usb_rst = 1'b0;
    chk_en  = 1'b1;
    step(1);
    check("post_rst_vp_s", 32'(vp_s), 32'd0);
    check("post_rst_se0_valid", 32'(se0_valid), 32'd0);
    check("post_rst_se1_err", 32'(se1_err), 32'd0);
    step(10);

    // Idle SE0, then the latency of a clean vp rise on both configurations.
    vp = 0;
    step(12);
    check("idle_se0_valid", 32'(se0_valid), 32'd1);
    vp = 1;
    n = 0; hit1 = 0; hit2 = 0; lat1 = -1; lat2 = -1;
    while (n < 20 && !(hit1 && hit2)) begin
      @(posedge usb_clk);
      n++;
      @(negedge usb_clk);
      if (!hit1 && vp_s) begin lat1 = n; hit1 = 1; end
      if (!hit2 && d2_vp_s) begin lat2 = n; hit2 = 1; end
    end
    check("latency_default", 32'(lat1), 32'd4);
    check("latency_ss3_fl1", 32'(lat2), 32'd4);
    check("latency_linestate", 32'(linestate), 32'b10);
    step(6);

    // One-cycle vm pulse is rejected and counted.
    vm = 1; step(1); vm = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge usb_clk);
      if (vm_s) cnt++;
    end
    check("glitch1_vm_s_high", 32'(cnt), 32'd0);
    check("glitch1_count", 32'(glitch_count), GC_EN ? 32'd1 : 32'd0);

    // Two-cycle vm pulse passes through as a two-cycle pulse.
    step(1);
    vm = 1; step(2); vm = 0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge usb_clk);
      if (vm_s) cnt++;
    end
    check("pulse2_vm_s_high", 32'(cnt), 32'd2);
    check("pulse2_count", 32'(glitch_count), GC_EN ? 32'd1 : 32'd0);

    // Ten-cycle SE0: rise 3 after filtered SE0, fall 1 after it ends.
    i_ls = -1; i_v = -1; i_e = -1; i_f = -1;
    for (int k = 0; k < 30; k++) begin
      vp = (k >= 10);
      @(posedge usb_clk);
      @(negedge usb_clk);
      if (i_ls < 0 && linestate == 2'b00) i_ls = k;
      if (i_ls >= 0 && i_v < 0 && se0_valid) i_v = k;
      if (i_v >= 0 && i_e < 0 && linestate != 2'b00) i_e = k;
      if (i_e >= 0 && i_f < 0 && !se0_valid) i_f = k;
    end
    check("se0_rise_delay", 32'(i_v - i_ls), 32'd3);
    check("se0_fall_delay", 32'(i_f - i_e), 32'd1);
    check("se0_seen", 32'(i_f >= 0), 32'd1);

    // Two-cycle filtered SE0 never qualifies.
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 14; k++) begin
      vp = !(k == 2 || k == 3);
      @(posedge usb_clk);
      @(negedge usb_clk);
      if (se0_valid) cnt++;
      if (linestate == 2'b00) cnt2++;
    end
    check("short_se0_valid", 32'(cnt), 32'd0);
    check("short_se0_len", 32'(cnt2), 32'd2);

    // SE1.
    step(1);
    vm = 1; step(8);
    check("se1_linestate", 32'(linestate), 32'b11);
    check("se1_err_set", 32'(se1_err), 32'd1);
    vm = 0; step(8);
    check("se1_err_clear", 32'(se1_err), 32'd0);

    // Random stimulus with occasional mid-operation resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rcv = ~rcv;
      if ($urandom_range(0, 3) == 0) vp  = ~vp;
      if ($urandom_range(0, 3) == 0) vm  = ~vm;
      usb_rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    usb_rst = 0;
    step(2);

    // Saturation: rcv and vm glitch on alternate edges, one reject per edge.
    usb_rst = 1; rcv = 0; vp = 1; vm = 0;
    step(2);
    usb_rst = 0;
    for (int k = 0; k < 66000; k++) begin
      rcv = (k % 2 == 1);
      vm  = (k % 2 == 0);
      step(1);
    end
    rcv = 0; vm = 0;
    step(4);
    check("sat_count", 32'(glitch_count), GC_EN ? 32'hFFFF : 32'h0);
    check("sat_vm_s", 32'(vm_s), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
